// File: rtl/booth_arbiter_if.sv
// Bundle of client-side request/result signals and the booth multiplier pins
// shared between booth_arbiter (slave) and its environment (master).
//
// Handshake: a client raises req[i] as a level with op_m/op_q stable and holds
// it until it sees a one-cycle done[i] (product valid) or err[i] (timeout);
// gnt is one-hot while its operation owns the multiplier.
interface booth_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] op_m;
  logic [8*N_REQ-1:0] op_q;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic [N_REQ-1:0]   err;
  logic [15:0]        product;
  logic [IDW-1:0]     product_id;
  logic [7:0]         mul_inbus;
  logic               mul_beginsig;
  logic               mul_locksig;
  logic [7:0]         mul_outbus;
  logic               mul_endsig;

  modport master (
    output req, op_m, op_q, mul_outbus, mul_endsig,
    input  gnt, done, err, product, product_id, mul_inbus, mul_beginsig, mul_locksig
  );

  modport slave (
    input  req, op_m, op_q, mul_outbus, mul_endsig,
    output gnt, done, err, product, product_id, mul_inbus, mul_beginsig, mul_locksig
  );
endinterface

// File: rtl/booth_arbiter.sv
// Round-robin front end that shares one 8-bit booth multiplier among N_REQ
// clients: sequences begin/lock, feeds operands, captures the dumped product.
module booth_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  booth_arbiter_if.slave       bus,
  output logic [2:0]           state_o
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    LOADQ = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4,
    ABORT = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] win_q, win_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [7:0]     s1_q, s1_d;
  logic [7:0]     s0_q, s0_d;
  logic [15:0]    prod_q, prod_d;
  logic [IDW-1:0] pid_q, pid_d;

  logic           found;
  logic [IDW-1:0] pick;
  int             idx;
  logic [7:0]     sel_m, sel_q;
  logic [N_REQ-1:0] win_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
      s1_q    <= '0;
      s0_q    <= '0;
      prod_q  <= '0;
      pid_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      s1_q    <= s1_d;
      s0_q    <= s0_d;
      prod_q  <= prod_d;
      pid_q   <= pid_d;
    end
  end

  // Round-robin search: first asserted req at or after ptr_q, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  always_comb begin
    sel_m = '0;
    sel_q = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (IDW'(k) == win_q) begin
        sel_m = bus.op_m[k*8 +: 8];
        sel_q = bus.op_q[k*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    s1_d    = s1_q;
    s0_d    = s0_q;
    prod_d  = prod_q;
    pid_d   = pid_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          ptr_d   = IDW'((int'(pick) + 1) % N_REQ);
          state_d = START;
        end
      end
      START: state_d = LOADQ;
      LOADQ: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        s1_d    = bus.mul_outbus;
        s0_d    = s1_q;
        // endsig wins over a coincident timeout; {s0,s1} holds {A,Q} here.
        if (bus.mul_endsig) begin
          prod_d  = {s0_q, s1_q};
          pid_d   = win_q;
          state_d = DONE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = ABORT;
        end
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_q;

  always_comb begin
    bus.gnt          = '0;
    bus.done         = '0;
    bus.err          = '0;
    bus.mul_inbus    = '0;
    bus.mul_beginsig = 1'b1;
    bus.mul_locksig  = 1'b0;
    case (state_q)
      START: begin
        bus.gnt          = win_onehot;
        bus.mul_inbus    = sel_m;
        bus.mul_beginsig = 1'b0;
        bus.mul_locksig  = 1'b1;
      end
      LOADQ: begin
        bus.gnt         = win_onehot;
        bus.mul_inbus   = sel_q;
        bus.mul_locksig = 1'b1;
      end
      WAIT: begin
        bus.gnt         = win_onehot;
        bus.mul_locksig = 1'b1;
      end
      DONE: begin
        bus.gnt  = win_onehot;
        bus.done = win_onehot;
      end
      ABORT: begin
        bus.gnt = win_onehot;
        bus.err = win_onehot;
      end
      default: ;
    endcase
  end

  assign bus.product    = prod_q;
  assign bus.product_id = pid_q;
  assign state_o        = state_q;
endmodule
